seven_segment_scan_ctrl: RTL and testbench
==========================================

Name: seven_segment_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one seven_segment decoder across NUM_DIGITS common-anode digits.
- Each cycle it presents one digit's nibble on digit_data, which feeds the shared decoder's data input, and drives that digit's active-low anode.
- Between digits it inserts a blanking gap to prevent ghosting.
- Display contents are double-buffered: an update handshake is applied only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2).
ON_CYCLES, 100000, clock cycles each digit's anode is asserted (>=1).
BLANK_CYCLES, 1000, clock cycles with all anodes off before each digit (>=1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  1 = scanning; 0 = display dark, scan held at digit 0.
update  input  1  1-cycle strobe: capture data_in/dp_in/blank_in into the pending buffer.
data_in  input  4*NUM_DIGITS  digit nibbles; digit k = bits [4k+3:4k], digit 0 is rightmost.
dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high.
blank_in  input  NUM_DIGITS  1 = keep this digit's anode off during its slot.
update_ack  output  1  1-cycle pulse when a capture becomes the active contents.
digit_data  output  4  nibble to the shared decoder.
digit_idx  output  $clog2(NUM_DIGITS)  index of the digit currently being scanned.
anode_n  output  NUM_DIGITS  active-low digit enables; at most one bit is 0.
dp_n  output  1  active-low decimal point for the current digit.
frame_done  output  1  1-cycle pulse after the last digit's SHOW slot ends.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; counter=0; digit_idx=0.
  - anode_n all 1; dp_n=1; digit_data=0.
  - update_ack=0; frame_done=0.
  - Active and pending buffers=0; pending_valid=0.
  - Reset mid-scan: outputs go to these values immediately (asynchronously).
- All outputs are registered.
- States:
  - IDLE: anodes off, digit_idx=0, counter=0. enable=1 -> BLANK on the next edge.
  - BLANK: anode_n all 1, dp_n=1. digit_data shows the active nibble of digit_idx, so the decoder settles before SHOW. After BLANK_CYCLES cycles -> SHOW, counter=0.
  - SHOW: anode_n[digit_idx]=0 unless blank_active[digit_idx]=1. dp_n = ~dp_active[digit_idx] when the anode is on, else 1. Lasts exactly ON_CYCLES cycles. Then:
    - digit_idx increments modulo NUM_DIGITS, and the state returns to BLANK.
    - On wrap (NUM_DIGITS-1 -> 0): frame_done pulses 1 cycle, coincident with the first BLANK cycle of digit 0.
- Digit period = BLANK_CYCLES+ON_CYCLES cycles; frame period = NUM_DIGITS times that.
- enable=0 in any state: IDLE on the next edge, anodes off the same edge, digit_idx=0. Re-enable restarts at digit 0 with BLANK.
- Update handshake:
  - update=1 copies inputs into the pending buffer and sets pending_valid.
  - A further update while pending_valid=1 overwrites pending (latest wins); only one ack is produced.
  - At the frame boundary (the edge entering digit 0's BLANK from the last SHOW), pending_valid=1 causes: active <= pending, pending_valid <= 0, update_ack pulses that same cycle.
  - update asserted on the boundary edge itself: the new inputs go directly to active and update_ack pulses. No stale pending value is applied.
  - While IDLE (enable=0): a pending update is applied on the next edge with update_ack, so the buffer stays current when dark.
- digit_data always reflects the active buffer; it changes only on digit change or on an active-buffer transfer.
- No segment inversion is done here; the decoder output polarity is handled downstream.

Test Plan:
- Params NUM_DIGITS=4, ON=4, BLANK=2. Reset, update with data_in=16'h4321, enable=1.
  - update_ack pulses once, on the next edge (IDLE apply).
  - anode_n sequence per 6-cycle slot: 1111 x2, 1110 x4, 1111 x2, 1101 x4, ...
  - digit_data: 1, 2, 3, 4.
  - frame_done pulses every 24 cycles.
- Mid-frame update to 16'hABCD:
  - The current frame continues to show 4321.
  - update_ack and the switch to D, C, B, A occur exactly at the frame_done cycle.
- Two updates in one frame (16'h1111, then 16'h2222): only one update_ack; the next frame shows 2222.
- blank_in=4'b0100, dp_in=4'b0001: digit 2's slot keeps anode_n=1111 and dp_n=1; dp_n=0 only during digit 0's 4 SHOW cycles.
- enable dropped during digit 2 SHOW: anode_n=1111 and digit_idx=0 on the next edge. Re-enable restarts with 2 BLANK cycles, then digit 0.
- rst_n asserted mid-SHOW: anode_n=1111, dp_n=1, active buffer=0 without waiting for a clock edge. After release and enable, the display shows 0000.

Source files
------------

// File: rtl/seven_segment_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_ctrl_if
// Bundles the control, update handshake and display-drive signals of the
// seven-segment scan controller.
//   master : the controlling side (drives enable/update/data/dp/blank,
//            observes ack, digit drive and frame strobe)
//   slave  : the scan controller itself
// Signals:
//   enable, update, data_in[4*N], dp_in[N], blank_in[N]     master -> slave
//   update_ack, digit_data[4], digit_idx[$clog2(N)],
//   anode_n[N], dp_n, frame_done                            slave -> master
// -----------------------------------------------------------------------------
interface seven_segment_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IW = $clog2(NUM_DIGITS);

  logic                      enable;
  logic                      update;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_in;
  logic                      update_ack;
  logic [3:0]                digit_data;
  logic [IW-1:0]             digit_idx;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic                      dp_n;
  logic                      frame_done;

  modport master (
    output enable, update, data_in, dp_in, blank_in,
    input  update_ack, digit_data, digit_idx, anode_n, dp_n, frame_done
  );

  modport slave (
    input  enable, update, data_in, dp_in, blank_in,
    output update_ack, digit_data, digit_idx, anode_n, dp_n, frame_done
  );
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing
// one seven-segment decoder. Each digit slot is BLANK_CYCLES with all anodes
// off (decoder settles on the new nibble) followed by ON_CYCLES with that
// digit's anode on. Display contents are double-buffered: updates land in a
// pending buffer and become active only at a frame boundary or while idle.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : seven_segment_scan_ctrl_if.slave (control, handshake, drive)
// All outputs are registered.
// -----------------------------------------------------------------------------
module seven_segment_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  seven_segment_scan_ctrl_if.slave      bus
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                    state_r, state_s;
  logic [CW-1:0]             cnt_r, cnt_s;
  logic [IW-1:0]             idx_r, idx_s;
  logic                      wrap_s;

  logic [4*NUM_DIGITS-1:0]   act_data_r, act_data_s;
  logic [NUM_DIGITS-1:0]     act_dp_r, act_dp_s;
  logic [NUM_DIGITS-1:0]     act_blank_r, act_blank_s;
  logic [4*NUM_DIGITS-1:0]   pend_data_r, pend_data_s;
  logic [NUM_DIGITS-1:0]     pend_dp_r, pend_dp_s;
  logic [NUM_DIGITS-1:0]     pend_blank_r, pend_blank_s;
  logic                      pend_valid_r, pend_valid_s;
  logic                      apply_s;

  logic                      update_ack_r, update_ack_s;
  logic                      frame_done_r;
  logic [3:0]                digit_data_r, digit_data_s;
  logic [NUM_DIGITS-1:0]     anode_n_r, anode_n_s;
  logic                      dp_n_r, dp_n_s;
  logic                      show_s;
  logic                      dp_on_s;

  // Scan sequencing: next state, slot counter and digit index.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    wrap_s  = 1'b0;
    if (!bus.enable) begin
      state_s = ST_IDLE;
      cnt_s   = '0;
      idx_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_BLANK;
          cnt_s   = '0;
          idx_s   = '0;
        end
        ST_BLANK: begin
          if (cnt_r == CW'(BLANK_CYCLES - 1)) begin
            state_s = ST_SHOW;
            cnt_s   = '0;
          end else begin
            cnt_s   = cnt_r + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_r == CW'(ON_CYCLES - 1)) begin
            state_s = ST_BLANK;
            cnt_s   = '0;
            if (idx_r == IW'(NUM_DIGITS - 1)) begin
              idx_s  = '0;
              wrap_s = 1'b1;
            end else begin
              idx_s  = idx_r + IW'(1);
            end
          end else begin
            cnt_s   = cnt_r + CW'(1);
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = '0;
          idx_s   = '0;
        end
      endcase
    end
  end

  // Double buffer: updates are staged in pending and promoted to active only
  // at a frame wrap or while idle. An update coinciding with the promotion
  // point bypasses pending so a stale pending value is never shown.
  always_comb begin
    act_data_s   = act_data_r;
    act_dp_s     = act_dp_r;
    act_blank_s  = act_blank_r;
    pend_data_s  = pend_data_r;
    pend_dp_s    = pend_dp_r;
    pend_blank_s = pend_blank_r;
    pend_valid_s = pend_valid_r;
    update_ack_s = 1'b0;
    apply_s      = wrap_s || (state_r == ST_IDLE);
    if (apply_s) begin
      if (bus.update) begin
        act_data_s   = bus.data_in;
        act_dp_s     = bus.dp_in;
        act_blank_s  = bus.blank_in;
        pend_valid_s = 1'b0;
        update_ack_s = 1'b1;
      end else if (pend_valid_r) begin
        act_data_s   = pend_data_r;
        act_dp_s     = pend_dp_r;
        act_blank_s  = pend_blank_r;
        pend_valid_s = 1'b0;
        update_ack_s = 1'b1;
      end else begin
        update_ack_s = 1'b0;
      end
    end else if (bus.update) begin
      pend_data_s  = bus.data_in;
      pend_dp_s    = bus.dp_in;
      pend_blank_s = bus.blank_in;
      pend_valid_s = 1'b1;
    end else begin
      pend_valid_s = pend_valid_r;
    end
  end

  // Digit drive decoded from the next state so the registered outputs line up
  // with the state register; selection is an AND-OR over the digit slots.
  always_comb begin
    show_s       = (state_s == ST_SHOW);
    digit_data_s = 4'h0;
    dp_on_s      = 1'b0;
    anode_n_s    = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_data_s = digit_data_s |
                     ((idx_s == IW'(k)) ? act_data_s[4*k +: 4] : 4'h0);
      anode_n_s[k] = ~(show_s && (idx_s == IW'(k)) && !act_blank_s[k]);
      dp_on_s      = dp_on_s |
                     (show_s && (idx_s == IW'(k)) && !act_blank_s[k] && act_dp_s[k]);
    end
    dp_n_s = ~dp_on_s;
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      idx_r        <= '0;
      act_data_r   <= '0;
      act_dp_r     <= '0;
      act_blank_r  <= '0;
      pend_data_r  <= '0;
      pend_dp_r    <= '0;
      pend_blank_r <= '0;
      pend_valid_r <= 1'b0;
      update_ack_r <= 1'b0;
      frame_done_r <= 1'b0;
      digit_data_r <= 4'h0;
      anode_n_r    <= '1;
      dp_n_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      idx_r        <= idx_s;
      act_data_r   <= act_data_s;
      act_dp_r     <= act_dp_s;
      act_blank_r  <= act_blank_s;
      pend_data_r  <= pend_data_s;
      pend_dp_r    <= pend_dp_s;
      pend_blank_r <= pend_blank_s;
      pend_valid_r <= pend_valid_s;
      update_ack_r <= update_ack_s;
      frame_done_r <= wrap_s;
      digit_data_r <= digit_data_s;
      anode_n_r    <= anode_n_s;
      dp_n_r       <= dp_n_s;
    end
  end

  assign bus.update_ack = update_ack_r;
  assign bus.frame_done = frame_done_r;
  assign bus.digit_data = digit_data_r;
  assign bus.digit_idx  = idx_r;
  assign bus.anode_n    = anode_n_r;
  assign bus.dp_n       = dp_n_r;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scan_ctrl
// Bench for seven_segment_scan_ctrl with NUM_DIGITS=4, ON=4, BLANK=2.
// A reference model tracks the position inside the frame as a plain cycle
// count and derives every output arithmetically; each cycle the outputs are
// compared against it. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_seven_segment_scan_ctrl;

  localparam int ND    = 4;
  localparam int ON    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = ON + BL;
  localparam int FRAME = ND * SLOT;

  logic clk;
  logic rst_n;

  seven_segment_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_segment_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .ON_CYCLES   (ON),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model state
  bit          m_run;
  int          m_t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_dp, m_blk, m_pdp, m_pblk;
  bit          m_pv, m_ack, m_fd;

  wire m_boundary = m_run && bus.enable && ((m_t % FRAME) == FRAME - 1);

  // Reference model: frame position counter plus the double-buffer rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_t <= 0;
      m_act <= 16'h0; m_dp <= 4'h0; m_blk <= 4'h0;
      m_pend <= 16'h0; m_pdp <= 4'h0; m_pblk <= 4'h0;
      m_pv <= 1'b0; m_ack <= 1'b0; m_fd <= 1'b0;
    end else begin
      m_fd  <= m_boundary;
      m_ack <= 1'b0;
      if (!m_run || m_boundary) begin
        if (bus.update) begin
          m_act <= bus.data_in; m_dp <= bus.dp_in; m_blk <= bus.blank_in;
          m_pv <= 1'b0; m_ack <= 1'b1;
        end else if (m_pv) begin
          m_act <= m_pend; m_dp <= m_pdp; m_blk <= m_pblk;
          m_pv <= 1'b0; m_ack <= 1'b1;
        end
      end else if (bus.update) begin
        m_pend <= bus.data_in; m_pdp <= bus.dp_in; m_pblk <= bus.blank_in;
        m_pv <= 1'b1;
      end
      if (!bus.enable) begin
        m_run <= 1'b0; m_t <= 0;
      end else if (!m_run) begin
        m_run <= 1'b1; m_t <= 0;
      end else begin
        m_t <= (m_t + 1) % FRAME;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    int p, d, idx;
    bit show, lit;
    logic [3:0] e_anode;
    logic e_dp;
    logic [15:0] act_copy;
    @(negedge clk);
    p    = m_t % FRAME;
    d    = p / SLOT;
    show = m_run && ((p % SLOT) >= BL);
    idx  = m_run ? d : 0;
    lit  = show && !m_blk[d];
    e_anode = 4'hF;
    if (lit) e_anode[d] = 1'b0;
    e_dp = lit ? ~m_dp[d] : 1'b1;
    act_copy = m_act;
    chk("model_anode_n",    32'(bus.anode_n),    32'(e_anode));
    chk("model_dp_n",       32'(bus.dp_n),       32'(e_dp));
    chk("model_digit_idx",  32'(bus.digit_idx),  32'(idx));
    chk("model_digit_data", 32'(bus.digit_data), 32'(act_copy[4*idx +: 4]));
    chk("model_update_ack", 32'(bus.update_ack), 32'(m_ack));
    chk("model_frame_done", 32'(bus.frame_done), 32'(m_fd));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int gap, acks, dpc, bc, found;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.update = 1'b0;
    bus.data_in = 16'h0; bus.dp_in = 4'h0; bus.blank_in = 4'h0;

    // Reset state
    tick();
    chk("rst_anode_n",    32'(bus.anode_n),    32'hF);
    chk("rst_dp_n",       32'(bus.dp_n),       32'h1);
    chk("rst_digit_data", 32'(bus.digit_data), 32'h0);
    chk("rst_digit_idx",  32'(bus.digit_idx),  32'h0);
    chk("rst_update_ack", 32'(bus.update_ack), 32'h0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;
    tick();

    // Update 4321 while idle together with enable: applied on the next edge
    bus.update = 1'b1; bus.enable = 1'b1; bus.data_in = 16'h4321;
    tick();
    bus.update = 1'b0;
    chk("idle_apply_ack",   32'(bus.update_ack), 32'h1);
    chk("first_blank_data", 32'(bus.digit_data), 32'h1);
    chk("first_blank_anode",32'(bus.anode_n),    32'hF);
    ticks(2);  // frame position 2
    chk("d0_show_anode",    32'(bus.anode_n),    32'hE);
    ticks(6);  // position 8
    chk("d1_show_anode",    32'(bus.anode_n),    32'hD);
    chk("d1_show_data",     32'(bus.digit_data), 32'h2);

    // Mid-frame update ABCD: held back until the frame boundary
    bus.update = 1'b1; bus.data_in = 16'hABCD;
    tick();    // position 9
    bus.update = 1'b0;
    chk("midframe_no_ack",  32'(bus.update_ack), 32'h0);
    ticks(11); // position 20, digit 3 show
    chk("d3_still_old",     32'(bus.digit_data), 32'h4);
    ticks(4);  // boundary
    chk("boundary_fd",      32'(bus.frame_done), 32'h1);
    chk("boundary_ack",     32'(bus.update_ack), 32'h1);
    chk("boundary_new_d0",  32'(bus.digit_data), 32'hD);

    // Frame period
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.frame_done) begin gap = i; break; end
    end
    chk("frame_period", 32'(gap), 32'd24);

    // Two updates in one frame: one ack, latest wins
    ticks(2);
    bus.update = 1'b1; bus.data_in = 16'h1111;
    tick();
    bus.update = 1'b0;
    ticks(3);
    bus.update = 1'b1; bus.data_in = 16'h2222;
    tick();
    bus.update = 1'b0;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.update_ack) acks++;
      if (bus.frame_done) chk("latest_wins_data", 32'(bus.digit_data), 32'h2);
    end
    chk("single_ack", 32'(acks), 32'd1);

    // Enable dropped during digit 2 SHOW (position 85 -> 110)
    ticks(25);
    chk("d2_show_anode", 32'(bus.anode_n), 32'hB);
    bus.enable = 1'b0;
    tick();
    chk("disable_anode", 32'(bus.anode_n),   32'hF);
    chk("disable_idx",   32'(bus.digit_idx), 32'h0);
    ticks(3);
    bus.enable = 1'b1;
    tick();
    chk("reen_blank0", 32'(bus.anode_n), 32'hF);
    tick();
    chk("reen_blank1", 32'(bus.anode_n), 32'hF);
    tick();
    chk("reen_show_d0", 32'(bus.anode_n), 32'hE);

    // Blank digit 2, decimal point on digit 0
    bus.update = 1'b1; bus.data_in = 16'h4321; bus.blank_in = 4'b0100; bus.dp_in = 4'b0001;
    tick();
    bus.update = 1'b0;
    ticks(21);
    chk("blank_apply_ack", 32'(bus.update_ack), 32'h1);
    dpc = 0; bc = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (bus.dp_n == 1'b0) dpc++;
      if (bus.anode_n == 4'hB) bc++;
    end
    chk("dp_cycles",      32'(dpc), 32'd4);
    chk("d2_blank_cycles",32'(bc),  32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.enable   = ($urandom_range(0, 49) != 0);
      bus.update   = ($urandom_range(0, 9) == 0);
      bus.data_in  = 16'($urandom);
      bus.dp_in    = 4'($urandom);
      bus.blank_in = 4'($urandom);
      tick();
    end

    // Asynchronous reset in the middle of a SHOW slot
    bus.enable = 1'b1; bus.update = 1'b1;
    bus.data_in = 16'h9876; bus.blank_in = 4'h0; bus.dp_in = 4'h0;
    tick();
    bus.update = 1'b0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.anode_n != 4'hF) begin found = 1; break; end
    end
    chk("show_reached", 32'(found), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_anode_n",    32'(bus.anode_n),    32'hF);
    chk("async_dp_n",       32'(bus.dp_n),       32'h1);
    chk("async_digit_data", 32'(bus.digit_data), 32'h0);
    chk("async_digit_idx",  32'(bus.digit_idx),  32'h0);
    tick();
    rst_n = 1'b1;
    ticks(3);
    chk("post_rst_anode", 32'(bus.anode_n),    32'hE);
    chk("post_rst_data",  32'(bus.digit_data), 32'h0);
    ticks(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
